// File: rtl/mac_operand_feeder.sv
// West-edge operand skew feeder for an N-row MAC systolic array.
// Lane i of each accepted vector is delayed i+1 cycles to form the diagonal wavefront.
module mac_operand_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic                    done,
    output logic                    err_len,
    input  logic                    vec_valid,
    output logic                    vec_ready,
    input  logic [N*DATA_WIDTH-1:0] vec_data,
    input  logic                    vec_last,
    output logic [N*DATA_WIDTH-1:0] a_edge,
    output logic [N-1:0]            a_edge_valid
);

    localparam int FLUSH_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
    localparam logic [FLUSH_W-1:0] FLUSH_ONE = FLUSH_W'(1);
    localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     k_q, k_d;
    logic [LEN_W-1:0]     beat_q, beat_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 kth_beat;

    assign vec_ready = (state_q == S_STREAM);
    assign accept    = vec_valid & vec_ready;
    assign kth_beat  = ((beat_q + LEN_ONE) == k_q);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err_len   = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (len != '0) begin
                        k_d     = len;
                        beat_d  = '0;
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    beat_d = beat_q + LEN_ONE;
                    // Framing mismatch is only flagged; the transfer always ends on count K.
                    if (vec_last != kth_beat) begin
                        err_d = 1'b1;
                    end
                    if (kth_beat) begin
                        flush_d = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_END) begin
                    state_d = S_DONE;
                end else begin
                    flush_d = flush_q + FLUSH_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skew network: lane g is a free-running shift chain of g+1 stages.
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] dat_q [0:g];
        logic                  vld_q [0:g];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int s = 0; s <= g; s++) begin
                    dat_q[s] <= '0;
                    vld_q[s] <= 1'b0;
                end
            end else begin
                dat_q[0] <= accept ? vec_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
                vld_q[0] <= accept;
                for (int s = 1; s <= g; s++) begin
                    dat_q[s] <= dat_q[s-1];
                    vld_q[s] <= vld_q[s-1];
                end
            end
        end

        assign a_edge[g*DATA_WIDTH +: DATA_WIDTH] = dat_q[g];
        assign a_edge_valid[g]                    = vld_q[g];
    end

endmodule
